// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - sequential AES key-schedule controller with progressive round-key read port
//
// Expands an Nk-word cipher key into 4*(Nr+1) words, one word per clock,
// through one shared 4-byte S-box. The expanded words sit in an internal
// buffer that the round engines read one 128-bit round key at a time.
//
// Parameters:
//   Nk           key length in 32-bit words (4 / 6 / 8)
//   Nr           number of rounds (10 / 12 / 14)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        expansion request, accepted only in IDLE
//   key_in       cipher key, word w0 in the most significant 32 bits
//   busy         high while words are being expanded
//   done         one-cycle pulse after the last word is written
//   rounds_avail number of complete round keys in the buffer
//   rk_rd_en     round-key read request
//   rk_idx       round key to read, 0..Nr
//   rk_out       registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//   rk_valid     rk_out holds the requested round key

module key_schedule_ctrl #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [Nk*32-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rounds_avail,
    input  logic              rk_rd_en,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk_out,
    output logic              rk_valid
);

    localparam int         NW          = 4 * (Nr + 1);
    localparam logic [5:0] NK_IDX      = 6'(Nk);
    localparam logic [5:0] LAST_IDX    = 6'(NW - 1);
    localparam logic [3:0] POS_LAST    = 4'(Nk - 1);
    localparam logic [3:0] INIT_ROUNDS = 4'(Nk / 4);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t state;

    logic [5:0]  idx;            // index i of the word written on the next expand edge
    logic [3:0]  pos;            // i mod Nk, tracked incrementally to avoid a divider
    logic [7:0]  rcon;
    logic [5:0]  words_written;  // word count once w[idx] lands

    // Sliding window of the last Nk words: oldest w[i-Nk] in the top word,
    // newest w[i-1] in the bottom word. Loaded straight from key_in on start.
    logic [Nk*32-1:0] win;

    // Round-key buffer; element 0 is w0 and sits at the MSB end so the key
    // load is a single slice assignment.
    logic [0:NW-1][31:0] mem;

    logic [31:0] prev_word;
    logic [31:0] oldest_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;
    logic [5:0]  rd_base;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign words_written = idx + 6'd1;
    assign rd_base       = {rk_idx, 2'b00};

    // Word generator. The single S-box word sees RotWord(w[i-1]) on the
    // Rcon step and w[i-1] itself on the extra AES-256 SubWord step.
    always_comb begin
        prev_word   = win[31:0];
        oldest_word = win[Nk*32-1 -: 32];
        sub_in      = (pos == 4'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out     = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                       SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};
        temp        = prev_word;
        if (pos == 4'd0) begin
            temp = sub_out ^ {rcon, 24'h000000};
        end else if (Nk > 6 && pos == 4'd4) begin
            temp = sub_out;
        end
        new_word = oldest_word ^ temp;
    end

    // Control FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rounds_avail <= 4'd0;
            rcon         <= 8'h01;
            idx          <= 6'd0;
            pos          <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= S_EXPAND;
                        busy         <= 1'b1;
                        idx          <= NK_IDX;
                        pos          <= 4'd0;
                        rcon         <= 8'h01;
                        rounds_avail <= INIT_ROUNDS;
                    end
                end
                S_EXPAND: begin
                    idx <= words_written;
                    pos <= (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
                    if (pos == 4'd0) begin
                        rcon <= xtime(rcon);
                    end
                    // Publish a round key only once its fourth word is written.
                    if (idx[1:0] == 2'b11) begin
                        rounds_avail <= words_written[5:2];
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Key window and round-key buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            win          <= key_in;
            mem[0:Nk-1]  <= key_in;
        end else if (state == S_EXPAND) begin
            win          <= {win[Nk*32-33:0], new_word};
            mem[idx]     <= new_word;
        end
    end

    // Registered read port. The bound uses rounds_avail before the edge, so
    // a round key completing on this edge reads back invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rk_out   <= 128'd0;
            rk_valid <= 1'b0;
        end else if (rk_rd_en) begin
            if (rk_idx < rounds_avail) begin
                rk_out   <= {mem[rd_base], mem[rd_base + 6'd1],
                             mem[rd_base + 6'd2], mem[rd_base + 6'd3]};
                rk_valid <= 1'b1;
            end else begin
                rk_out   <= 128'd0;
                rk_valid <= 1'b0;
            end
        end else begin
            rk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl (AES-128 and AES-256 instances)

module tb_key_schedule_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         sel;       // 0 drives the AES-128 instance, 1 the AES-256 instance
    logic         d_start;
    logic         d_rd;
    logic [255:0] d_key;
    logic [3:0]   d_idx;

    logic         a_busy, a_done, a_valid;
    logic [3:0]   a_ra;
    logic [127:0] a_rk;
    logic         b_busy, b_done, b_valid;
    logic [3:0]   b_ra;
    logic [127:0] b_rk;

    logic         s_busy, s_done, s_valid;
    logic [3:0]   s_ra;
    logic [127:0] s_rk;

    key_schedule_ctrl #(.Nk(4), .Nr(10)) dut128 (
        .clk          (clk),
        .reset        (reset),
        .start        (d_start & ~sel),
        .key_in       (d_key[127:0]),
        .busy         (a_busy),
        .done         (a_done),
        .rounds_avail (a_ra),
        .rk_rd_en     (d_rd & ~sel),
        .rk_idx       (d_idx),
        .rk_out       (a_rk),
        .rk_valid     (a_valid)
    );

    key_schedule_ctrl #(.Nk(8), .Nr(14)) dut256 (
        .clk          (clk),
        .reset        (reset),
        .start        (d_start & sel),
        .key_in       (d_key),
        .busy         (b_busy),
        .done         (b_done),
        .rounds_avail (b_ra),
        .rk_rd_en     (d_rd & sel),
        .rk_idx       (d_idx),
        .rk_out       (b_rk),
        .rk_valid     (b_valid)
    );

    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;
    assign s_valid = sel ? b_valid : a_valid;
    assign s_ra    = sel ? b_ra    : a_ra;
    assign s_rk    = sel ? b_rk    : a_rk;

    int checks = 0;
    int fails  = 0;

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (FIPS-197 key expansion) ----------------
    logic [7:0]  sbox_m [256];
    logic [31:0] mw [60];

    function automatic logic [7:0] xt(input logic [7:0] a);
        xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        gmul = p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        rotl8 = (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    task automatic build_sbox;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        subw = {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input int nr, input logic [255:0] key);
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                mw[i] = key[nk*32-1-32*i -: 32];
            end else begin
                logic [31:0] t = mw[i-1];
                if (i % nk == 0) begin
                    logic [7:0] rc = 8'h01;
                    for (int k = 1; k < i / nk; k++) rc = xt(rc);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                mw[i] = mw[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] mrk(input int r);
        mrk = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Starts an expansion and follows it cycle by cycle; with probe set it
    // also reads a random round key every cycle and checks progressive availability.
    task automatic expand_and_probe(input int nk, input int nr, input logic [255:0] key, input bit probe);
        int e = 4 * (nr + 1) - nk;
        int w = 4 * (nr + 1);
        int busy_cnt = 0;
        int done_cnt = 0;
        model_expand(nk, nr, key);
        d_key = key;
        d_start = 1'b1;
        d_rd = 1'b0;
        tick;
        d_start = 1'b0;
        chki("ra_after_start", int'(s_ra), nk / 4);
        if (s_busy) busy_cnt++;
        if (s_done) done_cnt++;
        for (int m = 1; m <= e + 2; m++) begin
            int idx = $urandom_range(0, 15);
            int ra_before = ((nk + m - 1 < w) ? nk + m - 1 : w) / 4;
            bit exp_v = (idx < ra_before);
            d_rd = probe;
            d_idx = 4'(idx);
            tick;
            if (s_busy) busy_cnt++;
            if (s_done) done_cnt++;
            chk1($sformatf("done_at_m%0d", m), s_done, (m == e));
            chki($sformatf("ra_at_m%0d", m), int'(s_ra), ((nk + m < w) ? nk + m : w) / 4);
            if (probe) begin
                chk1($sformatf("prog_valid_m%0d_idx%0d", m, idx), s_valid, exp_v);
                chk128($sformatf("prog_rk_m%0d_idx%0d", m, idx), s_rk, exp_v ? mrk(idx) : 128'd0);
            end
        end
        d_rd = 1'b0;
        chki("busy_cycles", busy_cnt, e);
        chki("done_pulses", done_cnt, 1);
    endtask

    task automatic read_key(input int idx, output logic [127:0] rk, output logic v);
        d_rd = 1'b1;
        d_idx = 4'(idx);
        tick;
        rk = s_rk;
        v = s_valid;
        d_rd = 1'b0;
    endtask

    typedef struct {
        bit           wide;
        logic [255:0] key;
        int           idx;
        logic [127:0] rk;
        bit           v;
    } vec_t;

    localparam logic [255:0] K128 = {128'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KALT = {128'd0, 128'h000102030405060708090a0b0c0d0e0f};

    vec_t vt [10];

    initial begin
        logic [127:0] rk;
        logic         v;
        int           busy_cnt;
        int           done_cnt;

        vt[0] = '{1'b0, K128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};
        vt[1] = '{1'b0, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
        vt[2] = '{1'b0, K128, 2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b1};
        vt[3] = '{1'b0, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        vt[4] = '{1'b0, K128, 11, 128'd0, 1'b0};
        vt[5] = '{1'b1, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1};
        vt[6] = '{1'b1, K256, 0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b1};
        vt[7] = '{1'b1, K256, 1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b1};
        vt[8] = '{1'b1, K256, 15, 128'd0, 1'b0};
        vt[9] = '{1'b0, 256'd0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1};

        build_sbox();

        reset = 1'b1;
        sel = 1'b0;
        d_start = 1'b0;
        d_rd = 1'b0;
        d_key = '0;
        d_idx = 4'd0;
        tick;
        tick;

        // Reset state of both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            chk1($sformatf("rst_busy_%0d", s), s_busy, 1'b0);
            chk1($sformatf("rst_done_%0d", s), s_done, 1'b0);
            chki($sformatf("rst_ra_%0d", s), int'(s_ra), 0);
            chk1($sformatf("rst_valid_%0d", s), s_valid, 1'b0);
            chk128($sformatf("rst_rk_%0d", s), s_rk, 128'd0);
        end

        // Reset and start on the same edge: reset wins.
        sel = 1'b0;
        d_key = K128;
        d_start = 1'b1;
        tick;
        reset = 1'b0;
        d_start = 1'b0;
        chk1("rst_start_busy", s_busy, 1'b0);
        tick;
        chk1("rst_start_busy_later", s_busy, 1'b0);
        chki("rst_start_ra", int'(s_ra), 0);

        // Progressive reads from a fresh (empty) buffer, AES-128.
        expand_and_probe(4, 10, K128, 1'b1);

        // Table vectors; each runs a full expansion with progressive probing.
        for (int t = 0; t < 10; t++) begin
            sel = vt[t].wide;
            expand_and_probe(vt[t].wide ? 8 : 4, vt[t].wide ? 14 : 10, vt[t].key, 1'b1);
            read_key(vt[t].idx, rk, v);
            chk1($sformatf("vec%0d_valid", t), v, vt[t].v);
            chk128($sformatf("vec%0d_rk", t), rk, vt[t].rk);
        end

        // rk_rd_en low holds rk_out and clears rk_valid.
        sel = 1'b0;
        expand_and_probe(4, 10, K128, 1'b0);
        read_key(1, rk, v);
        chk128("hold_pre_rk", rk, 128'ha0fafe1788542cb123a339392a6c7605);
        tick;
        chk1("hold_valid", s_valid, 1'b0);
        chk128("hold_rk", s_rk, 128'ha0fafe1788542cb123a339392a6c7605);

        // start held through the expansion, key changed mid-run.
        sel = 1'b0;
        d_key = K128;
        d_start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int m = 0; m < 60; m++) begin
            if (m == 20) d_key = KALT;
            tick;
            if (s_busy) busy_cnt++;
            if (s_done) begin
                done_cnt++;
                d_start = 1'b0;
            end
        end
        d_start = 1'b0;
        chki("held_start_busy_cycles", busy_cnt, 40);
        chki("held_start_done_pulses", done_cnt, 1);
        read_key(10, rk, v);
        chk1("held_start_valid", v, 1'b1);
        chk128("held_start_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset in the middle of an expansion.
        sel = 1'b0;
        d_key = K128;
        d_start = 1'b1;
        tick;
        d_start = 1'b0;
        repeat (20) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk1("midrst_busy", s_busy, 1'b0);
        chk1("midrst_done", s_done, 1'b0);
        chki("midrst_ra", int'(s_ra), 0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int m = 0; m < 50; m++) begin
            tick;
            if (s_done) done_cnt++;
            if (s_busy) busy_cnt++;
        end
        chki("midrst_no_done", done_cnt, 0);
        chki("midrst_no_busy", busy_cnt, 0);
        read_key(0, rk, v);
        chk1("midrst_read_invalid", v, 1'b0);
        expand_and_probe(4, 10, K128, 1'b1);
        read_key(1, rk, v);
        chk128("midrst_redo_rk1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
        read_key(10, rk, v);
        chk128("midrst_redo_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Randomised keys on both instances against the reference model.
        for (int it = 0; it < 8; it++) begin
            logic [255:0] key = {$urandom(), $urandom(), $urandom(), $urandom(),
                                 $urandom(), $urandom(), $urandom(), $urandom()};
            bit wide = 1'($urandom_range(0, 1));
            int nr = wide ? 14 : 10;
            sel = wide;
            if (!wide) key[255:128] = '0;
            expand_and_probe(wide ? 8 : 4, nr, key, 1'b1);
            for (int r = 0; r < 6; r++) begin
                int idx = $urandom_range(0, 15);
                read_key(idx, rk, v);
                chk1($sformatf("rnd%0d_valid_idx%0d", it, idx), v, (idx <= nr));
                chk128($sformatf("rnd%0d_rk_idx%0d", it, idx), rk, (idx <= nr) ? mrk(idx) : 128'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequential AES key-schedule controller. It expands a cipher key into Nr+1 round keys, producing one 32-bit word per clock through a single shared 4-byte S-box. The expanded words are stored in an internal round-key buffer. The cipher/decipher round engines read that buffer through a registered read port. Round keys become readable progressively, so the cipher may start round 0 before expansion finishes.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256)
Nr, 10, number of rounds (10/12/14); the legal pairs are (4,10), (6,12) and (8,14)

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request an expansion of key_in; sampled only in IDLE
key_in  in  Nk*32  cipher key; bits [Nk*32-1 -: 32] are word w0
busy  out  1  high while an expansion is in progress
done  out  1  one-cycle pulse after the last word is written
rounds_avail  out  4  number of complete round keys held in the buffer
rk_rd_en  in  1  round-key read request
rk_idx  in  4  index of the round key to read, 0..Nr
rk_out  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, MSB first
rk_valid  out  1  rk_out holds a valid round key

Behaviour:
- Reset: state=IDLE; busy, done, rk_valid=0; rounds_avail=0; rk_out=0; the Rcon register is set to 8'h01. Buffer contents are don't-care after reset.
- States:
  - IDLE -> EXPAND on start=1. The same edge loads w0..w(Nk-1) from key_in, sets i=Nk, sets Rcon=01, sets busy=1 and sets rounds_avail=floor(Nk/4).
  - EXPAND: each edge writes one word w[i] and increments i. When the word w[4(Nr+1)-1] is written, the state goes to DONE and busy drops on that same edge.
  - DONE: done=1 for exactly one cycle, then the state returns to IDLE. start is ignored in DONE.
- Word generation at index i:
  - temp=w[i-1].
  - If i%Nk==0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, and Rcon <= xtime(Rcon). xtime is a left shift, XOR 8'h1b if bit 7 was set.
  - Else if Nk>6 and i%Nk==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - RotWord rotates the word left by one byte. SubWord applies the AES S-box to each byte.
  - Only one 4-byte S-box instance exists.
- Latency from the start edge to the done pulse: 4(Nr+1)-Nk expand cycles, i.e. 40 / 46 / 52 cycles for AES-128/192/256. done is high during the cycle after the last expand edge.
- rounds_avail = floor(words_written/4). It updates on the edge that completes each group of 4 words and holds Nr+1 after completion until the next accepted start or a reset.
- Read port:
  - On an edge with rk_rd_en=1: if rk_idx < rounds_avail (value before the edge), then rk_out <= round key rk_idx and rk_valid <= 1.
  - Otherwise rk_out <= 0 and rk_valid <= 0.
  - rk_rd_en=0 gives rk_valid <= 0 and rk_out holds its value.
  - Read latency is 1 cycle. Reads are allowed in any state, including concurrently with expansion.
- A read of the round key completed on the same edge returns invalid; the requester retries next cycle.
- start while busy (EXPAND or DONE) is ignored; the expansion in progress is not disturbed.
- key_in is sampled only on the accepting edge; later changes to key_in have no effect.
- A new start after completion restarts expansion: rounds_avail reloads to floor(Nk/4) on that edge, and older round keys are no longer readable.
- Reset mid-expansion: on the next edge the state is IDLE with all outputs at their reset values. No done pulse is produced for the aborted expansion.
- If reset and start are high on the same edge, reset wins.
- i needs 6 bits (maximum 59). Rcon must never exceed 8'h36 for legal (Nk,Nr) pairs.

Test Plan:
1. AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> busy for 40 cycles, done one cycle after the last expand edge; rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. AES-256 (Nk=8, Nr=14), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 52 expand cycles; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e (exercises the i%Nk==4 SubWord path).
3. Progressive read, AES-128: read rk_idx=2 every cycle from the start edge -> rk_valid=0 until rounds_avail reaches 3, then the data equals the expected round-2 key; rk_idx=11 -> rk_valid=0 and rk_out=0 always.
4. start held high for the whole expansion -> exactly one expansion and one done pulse; a second key applied mid-run is ignored; results match test 1.
5. Reset asserted at expand cycle 20 -> next cycle busy=0, rounds_avail=0, no done pulse; a fresh start then reproduces test 1 exactly (Rcon restarts at 01).
6. Back-to-back keys: after done, start with the all-zero key -> round 10 key b4ef5bcb3e92e21123e951cf6f8f188e; rounds_avail drops to 1 on the start edge.
